dcache_dm_wt: RTL and testbench
===============================

Name: dcache_dm_wt

Overview:
- Parametrised direct-mapped, one-word-per-line data cache between the MEM stage and data memory.
- Write-through, no-write-allocate.
- Memory side uses a variable-latency req/ack handshake; the cache stalls the pipeline on misses and writes.
- Adds a flush input and hit/miss performance counters.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width (word-aligned accesses only).
- SETS, 8, number of lines; power of two, at least 2. IDX = log2(SETS). TAG = ADDR_WIDTH-IDX-2.
- CNT_WIDTH, 32, width of the perf counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  access request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_req & ~cpu_we & ~cpu_stall.
- cpu_stall  out  1  hold the pipeline.
- flush  in  1  invalidate all lines.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address {cpu_addr[ADDR_WIDTH-1:2],2'b00}.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  single-cycle completion pulse.
- hit_count  out  CNT_WIDTH  load hits.
- miss_count  out  CNT_WIDTH  load misses.

Behaviour:
- Line layout: valid, tag[TAG], data[DATA_WIDTH].
  - index = cpu_addr[IDX+1:2]; tag = cpu_addr[ADDR_WIDTH-1:IDX+2].
  - hit = valid[index] & tag match.
- Arrays are clocked; the lookup is combinational (same cycle).
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - load hit: cpu_rdata = line data, cpu_stall = 0, no memory traffic, 0-cycle latency.
  - load miss: cpu_stall = 1; next state FILL.
  - store: cpu_stall = 1; next state WRITE.
  - no request: cpu_stall = 0.
- FILL:
  - mem_req = 1, mem_we = 0, cpu_stall = 1.
  - on mem_ack: write line (valid=1, tag, mem_rdata), go to IDLE.
  - the pipeline replays the held request the next cycle and hits.
  - total load-miss stall = memory latency + 1 cycles.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_wdata = cpu_wdata.
  - cpu_stall = 1 until the mem_ack cycle, where cpu_stall = 0 and the state returns to IDLE.
  - on ack, if the line hits, its data is updated to cpu_wdata; on miss, the cache is unchanged (no allocate).
- Outside FILL/WRITE: mem_req = 0, mem_we = 0.
- cpu_addr, cpu_we and cpu_wdata are stable while stalled; the cache does not latch them.
- Counters (wrap on overflow):
  - hit_count +1 on an IDLE load hit, excluding the first IDLE cycle after a fill. A registered replay flag is set on fill ack and cleared the next cycle.
  - miss_count +1 on the IDLE->FILL transition.
  - stores are not counted.
- Flush: clears all valid bits at the clock edge, in any state. The FSM and counters are unaffected.
  - If flush coincides with a fill ack, flush wins: the line is left invalid, the replay misses and refills, and miss_count increments again.
- mem_ack while in IDLE is ignored.
- Reset: state = IDLE, all valid bits = 0, counters = 0, replay flag = 0.
  - Outputs after reset: mem_req = 0, mem_we = 0, cpu_stall = 0 with cpu_req low, cpu_rdata = 0 when no load hit.
  - Reset during FILL/WRITE aborts the access; mem_req drops the cycle after reset; a late mem_ack is ignored.
- Data contents need no reset; only the valid bits are reset.

Test Plan:
- SETS=8, mem latency 3. Load 0x100 cold -> stall 4 cycles, mem_req/mem_addr=0x100 for 3 cycles; then cpu_rdata=0xDEADBEEF; miss_count=1, hit_count=0. Second load 0x100 -> 0 stall, hit_count=1.
- Conflict: fill 0x100, then load 0x120 (same index 0, new tag) -> miss, refill. Load 0x100 again -> miss; miss_count=3.
- Store 0x100=0x12345678 on a resident line, latency 2 -> mem_we=1, mem_wdata=0x12345678; stall released in the ack cycle. Next load 0x100 hits with 0x12345678.
- Store miss to 0x140 -> memory written, no allocate. Subsequent load 0x140 misses, miss_count increments.
- Flush after filling 0x100 and 0x104 -> both next loads miss. Flush in the same cycle as a fill ack -> the replay misses again.
- Assert rst in FILL cycle 2 -> mem_req=0 next cycle; a late mem_ack is ignored; counters=0; load 0x100 misses.

Source files
------------

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// Lookup is combinational against clocked tag/data/valid arrays; misses and
// stores stall the pipeline while a single memory transaction is in flight.
//
// Memory handshake: mem_req (with mem_we/mem_addr/mem_wdata) is held high and
// stable from the first FILL/WRITE cycle until the cycle in which mem_ack is
// sampled high; mem_ack is a one-cycle completion pulse and carries mem_rdata
// for reads. An mem_ack seen while no request is outstanding is ignored.
module dcache_dm_wt #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [1:0]            o_dbg_state
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_WIDTH - IDX - 2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [SETS-1:0]       r_valid;
    logic [TAG-1:0]        r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS];
    logic                  r_replay;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;

    logic [IDX-1:0] w_idx;
    logic [TAG-1:0] w_tag;
    logic           w_hit;
    logic           w_load_hit;
    logic           w_load_miss;
    logic           w_fill_ack;
    logic           w_write_ack;
    logic           w_unused_addr_lsb;

    assign w_idx       = cpu_addr[IDX+1:2];
    assign w_tag       = cpu_addr[ADDR_WIDTH-1:IDX+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_load_hit  = (r_state == ST_IDLE) && cpu_req && !cpu_we && w_hit;
    assign w_load_miss = (r_state == ST_IDLE) && cpu_req && !cpu_we && !w_hit;
    assign w_fill_ack  = (r_state == ST_FILL) && mem_ack;
    assign w_write_ack = (r_state == ST_WRITE) && mem_ack;

    // Byte offset is irrelevant for word-aligned accesses.
    assign w_unused_addr_lsb = ^cpu_addr[1:0];

    assign mem_addr    = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata   = cpu_wdata;
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;
    assign o_dbg_state = r_state;

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall = 1'b1;
                        w_next    = ST_WRITE;
                    end else if (w_hit) begin
                        cpu_rdata = r_data[w_idx];
                    end else begin
                        cpu_stall = 1'b1;
                        w_next    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                mem_req   = 1'b1;
                cpu_stall = 1'b1;
                if (mem_ack) w_next = ST_IDLE;
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                cpu_stall = !mem_ack;
                if (mem_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Valid bits: flush and reset beat a coincident fill.
    always_ff @(posedge clk) begin
        if (rst || flush)    r_valid        <= '0;
        else if (w_fill_ack) r_valid[w_idx] <= 1'b1;
    end

    // Tag/data arrays: fill on read ack, update in place on a write-through hit.
    always_ff @(posedge clk) begin
        if (w_fill_ack) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_rdata;
        end else if (w_write_ack && w_hit) begin
            r_data[w_idx] <= cpu_wdata;
        end
    end

    // Perf counters; the replay of a just-filled load is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_replay     <= 1'b0;
        end else begin
            r_replay <= w_fill_ack;
            if (w_load_hit && !r_replay) r_hit_count  <= r_hit_count + CNT_ONE;
            if (w_load_miss)             r_miss_count <= r_miss_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_dcache_dm_wt.sv
// Directed plus randomized bench for dcache_dm_wt with a word-level cache
// model (line holds a word address) and a sparse backing-memory model.
module tb_dcache_dm_wt;
    localparam int SETS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    logic [31:0] mem_model [int];
    bit          m_valid [SETS];
    int          m_word  [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] m_hit = 0;
    logic [31:0] m_miss = 0;

    dcache_dm_wt #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(SETS), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input int w);
        if (!mem_model.exists(w)) mem_model[w] = $urandom;
        return mem_model[w];
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic chk_counters();
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
    endtask

    // One CPU access; called right after a rising edge. Acts as the memory,
    // acking after lat request cycles; optionally flushes on the first ack.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input bit fl_ack);
        int          w = int'(addr >> 2);
        int          idx = w % SETS;
        bit          hit = m_valid[idx] && (m_word[idx] == w);
        int          exp_stall, exp_req, fills;
        int          stall_n = 0, req_n = 0, burst = 0;
        bit          done = 1'b0;
        bit          fl_pend = fl_ack;
        logic [31:0] got_rd = '0;
        logic [31:0] exp_rd = '0;
        logic [31:0] exp_addr = {addr[31:2], 2'b00};

        if (we) begin
            exp_stall = lat; exp_req = lat;
        end else if (hit) begin
            exp_stall = 0; exp_req = 0;
        end else begin
            fills = fl_ack ? 2 : 1;
            exp_stall = fills * (lat + 1); exp_req = fills * lat;
        end

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                req_n++; burst++;
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", mem_we, we);
                if (we) chk("mem_wdata", mem_wdata, wd);
                if (burst == lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_read(w);
                    burst = 0;
                    if (fl_pend) begin flush = 1'b1; fl_pend = 1'b0; end
                end
            end
            #1;
            if (cpu_stall) begin
                stall_n++;
                chk("rdata_while_stalled", cpu_rdata, 32'h0);
            end else begin
                done = 1'b1;
                got_rd = cpu_rdata;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; flush = 1'b0; mem_rdata = $urandom;
        end
        cpu_req = 1'b0;
        if (!done) chk("access_timeout", 0, 1);

        // advance the model
        if (we) begin
            mem_model[w] = wd;
            if (hit) m_data[idx] = wd;
            if (fl_ack) model_flush();
        end else if (hit) begin
            m_hit++;
            exp_rd = m_data[idx];
        end else begin
            if (fl_ack) begin m_miss += 2; model_flush(); end
            else m_miss += 1;
            m_valid[idx] = 1'b1; m_word[idx] = w; m_data[idx] = mem_model[w];
            exp_rd = mem_model[w];
        end

        chk(we ? "store_stall_cycles" : "load_stall_cycles", stall_n, exp_stall);
        chk("mem_req_cycles", req_n, exp_req);
        if (!we) chk("load_rdata", got_rd, exp_rd);
        chk_counters();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
    endtask

    initial begin
        logic [31:0] a, d;
        int lat;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk_counters();
        @(posedge clk); #1;

        // cold miss then hit
        mem_model[32'h100 >> 2] = 32'hDEADBEEF;
        access(0, 32'h100, 0, 3, 0);
        chk("cold_miss_count", miss_count, 1);
        access(0, 32'h100, 0, 3, 0);
        chk("warm_hit_count", hit_count, 1);

        // conflict on index 0
        access(0, 32'h120, 0, 3, 0);
        access(0, 32'h100, 0, 3, 0);
        chk("conflict_miss_count", miss_count, 3);

        // store hit updates resident line
        access(1, 32'h100, 32'h12345678, 2, 0);
        access(0, 32'h100, 0, 2, 0);
        chk("store_hit_reload", m_data[0], 32'h12345678);

        // store miss: no allocate
        access(1, 32'h140, 32'hCAFEF00D, 2, 0);
        access(0, 32'h140, 0, 2, 0);

        // flush after two fills, then flush colliding with a fill ack
        access(0, 32'h100, 0, 1, 0);
        access(0, 32'h104, 0, 1, 0);
        do_flush();
        access(0, 32'h100, 0, 2, 0);
        access(0, 32'h104, 0, 2, 0);
        access(0, 32'h108, 0, 3, 1);
        access(0, 32'h108, 0, 3, 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, SETS - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = a | 32'h0001_0000;
            d = $urandom;
            lat = $urandom_range(1, 4);
            case ($urandom_range(0, 19))
                0:       do_flush();
                1:       access($urandom_range(0, 1), a, d, lat, 1);
                2, 3, 4, 5, 6: access(1, a, d, lat, 0);
                default: access(0, a, d, lat, 0);
            endcase
        end

        // reset in the second FILL cycle aborts the fill
        do_flush();
        void'(mem_read(32'h100 >> 2));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(posedge clk); #1;                 // now FILL cycle 1
        @(posedge clk); #1;                 // now FILL cycle 2
        rst = 1'b1;
        @(negedge clk);
        chk("fill2_mem_req", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0;
        m_hit = 0; m_miss = 0; model_flush();
        @(negedge clk);
        chk("post_rst_mem_req", mem_req, 0);
        chk("post_rst_stall", cpu_stall, 0);
        chk_counters();
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;   // late ack
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_mem_req", mem_req, 0);
        chk_counters();
        @(posedge clk); #1;
        access(0, 32'h100, 0, 3, 0);
        chk("post_rst_miss_count", miss_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
